// File: rtl/tt_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : tt_ctrl_pkg                                                 |
// | Description: Shared control encodings for the set/clear flag bank:       |
// |              the 2-bit conflict-mode type and the per-channel            |
// |              set/clear resolution helper.                                |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package tt_ctrl_pkg;

    // Behaviour when set and clear are both asserted on one channel.
    typedef enum logic [1:0] {
        MODE_SET_WINS = 2'b00,
        MODE_CLR_WINS = 2'b01,
        MODE_HOLD     = 2'b10,
        MODE_TOGGLE   = 2'b11
    } mode_t;

    // Next flag value from the qualified set/clear pair and the current value.
    function automatic logic resolve_next(input logic s, input logic c,
                                          input logic q, input mode_t mode);
        logic nxt;
        nxt = q;
        case ({s, c})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
                case (mode)
                    MODE_SET_WINS: nxt = 1'b1;
                    MODE_CLR_WINS: nxt = 1'b0;
                    MODE_HOLD:     nxt = q;
                    MODE_TOGGLE:   nxt = ~q;
                    default:       nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage : tt_ctrl_pkg
`default_nettype wire

// File: rtl/sr_latch_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface  : sr_latch_bank_if                                            |
// | Description: Request/status bundle of the set/clear flag bank.           |
// |   set_i/clr_i  N   per-channel set / clear requests                      |
// |   mode_i       2   conflict mode (tt_ctrl_pkg::mode_t)                   |
// |   excl_i       1   exclusive (one-hot) group mode                        |
// |   q_o/chg_o    N   registered flags / one-cycle change pulses            |
// |   cnt_o        CW  number of set flags                                   |
// |   any_o        1   at least one flag set                                 |
// |   master: drives requests (control logic / bench); slave: the bank.      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface sr_latch_bank_if #(
    parameter int N = 4
);
    import tt_ctrl_pkg::*;

    localparam int c_cnt_w = $clog2(N + 1);

    logic [N-1:0]       set_i;
    logic [N-1:0]       clr_i;
    mode_t              mode_i;
    logic               excl_i;
    logic [N-1:0]       q_o;
    logic [N-1:0]       chg_o;
    logic [c_cnt_w-1:0] cnt_o;
    logic               any_o;

    modport master (
        output set_i, clr_i, mode_i, excl_i,
        input  q_o, chg_o, cnt_o, any_o
    );

    modport slave (
        input  set_i, clr_i, mode_i, excl_i,
        output q_o, chg_o, cnt_o, any_o
    );

endinterface : sr_latch_bank_if
`default_nettype wire

// File: rtl/sr_latch_bank_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : sr_cell                                                     |
// | Description: One channel of the flag bank. Holds the input edge history, |
// |              qualifies set/clear (level or rising edge) and resolves the |
// |              channel's next value. The flag register itself lives in the |
// |              top so exclusive mode can override it.                      |
// |   clk, rst_n        clock, synchronous active-low reset                   |
// |   set_i, clr_i      raw requests for this channel                         |
// |   q_i               current flag value                                    |
// |   mode_i            conflict mode                                         |
// |   s_o               qualified set (feeds the exclusive encoder)           |
// |   nxt_o             resolved next value                                   |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module sr_cell
    import tt_ctrl_pkg::*;
#(
    parameter bit EDGE = 1'b0
) (
    input  wire   clk,
    input  wire   rst_n,
    input  wire   set_i,
    input  wire   clr_i,
    input  wire   q_i,
    input  mode_t mode_i,
    output logic  s_o,
    output logic  nxt_o
);

    logic r_set_d;
    logic r_clr_d;
    logic w_set_mask;
    logic w_clr_mask;
    logic w_c;

    // History clears on reset, so a request already high in the first cycle
    // after reset is treated as a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_set_d <= 1'b0;
            r_clr_d <= 1'b0;
        end else begin
            r_set_d <= set_i;
            r_clr_d <= clr_i;
        end
    end

    // In level mode the history is masked off and the raw inputs pass through.
    assign w_set_mask = EDGE ? r_set_d : 1'b0;
    assign w_clr_mask = EDGE ? r_clr_d : 1'b0;

    assign s_o   = set_i & ~w_set_mask;
    assign w_c   = clr_i & ~w_clr_mask;
    assign nxt_o = resolve_next(s_o, w_c, q_i, mode_i);

endmodule : sr_cell
`default_nettype wire

// File: rtl/sr_latch_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : sr_latch_bank                                               |
// | Description: Bank of N clocked set/clear flags with selectable conflict  |
// |              resolution, optional rising-edge qualification, exclusive   |
// |              (one-hot) group mode, change pulses and an active count.    |
// |   clk     clock, all state on the rising edge                            |
// |   rst_n   synchronous active-low reset (q=RST_VAL, chg=0, history=0)     |
// |   bus     sr_latch_bank_if.slave: set/clr/mode/excl in, q/chg/cnt/any out|
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module sr_latch_bank
    import tt_ctrl_pkg::*;
#(
    parameter int           N       = 4,
    parameter bit           EDGE    = 1'b0,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  wire            clk,
    input  wire            rst_n,
    sr_latch_bank_if.slave bus
);

    localparam int c_cnt_w = $clog2(N + 1);

    logic [N-1:0]       w_s;
    logic [N-1:0]       w_nxt;
    logic [N-1:0]       w_cand;
    logic [N-1:0]       w_win;
    logic [N-1:0]       w_q_next;
    logic [c_cnt_w-1:0] w_cnt;
    logic [N-1:0]       r_q;
    logic [N-1:0]       r_chg;

    for (genvar i = 0; i < N; i++) begin : g_cell
        sr_cell #(
            .EDGE (EDGE)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .set_i  (bus.set_i[i]),
            .clr_i  (bus.clr_i[i]),
            .q_i    (r_q[i]),
            .mode_i (bus.mode_i),
            .s_o    (w_s[i]),
            .nxt_o  (w_nxt[i])
        );
    end

    // A channel can win exclusive mode only if its set survived conflict
    // resolution. x & -x isolates the lowest set bit, i.e. lowest index wins.
    assign w_cand = w_s & w_nxt;
    assign w_win  = w_cand & (~w_cand + N'(1));

    // Without a winner, exclusive mode falls back to plain clears/holds, so
    // bits already set on entry persist until a winner or explicit clear.
    always_comb begin
        w_q_next = w_nxt;
        if (bus.excl_i && (|w_cand)) begin
            w_q_next = w_win;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q   <= RST_VAL;
            r_chg <= '0;
        end else begin
            r_q   <= w_q_next;
            r_chg <= r_q ^ w_q_next;
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt = w_cnt + c_cnt_w'(r_q[i]);
        end
    end

    assign bus.q_o   = r_q;
    assign bus.chg_o = r_chg;
    assign bus.cnt_o = w_cnt;
    assign bus.any_o = |r_q;

endmodule : sr_latch_bank
`default_nettype wire

// File: tb/tb_sr_latch_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_sr_latch_bank                                            |
// | Description: Directed self-checking bench for sr_latch_bank. Four        |
// |              instances: N=4 level (main), N=4 edge with RST_VAL=1001,    |
// |              N=8 and N=1 width corners. Expected results are queued when |
// |              a step is driven and popped after the clock edge.           |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_sr_latch_bank;
    import tt_ctrl_pkg::*;

    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] q;
        logic [7:0] chg;
    } exp_t;

    logic       clk = 1'b0;
    logic [3:0] rst_n_v = 4'b0000;
    int         n_assert = 0;
    int         n_fail   = 0;
    exp_t       sb[$];

    sr_latch_bank_if #(.N(4)) if_a ();
    sr_latch_bank_if #(.N(4)) if_b ();
    sr_latch_bank_if #(.N(8)) if_c ();
    sr_latch_bank_if #(.N(1)) if_d ();

    sr_latch_bank #(.N(4), .EDGE(1'b0), .RST_VAL(4'b0000)) u_dut_a (
        .clk (clk), .rst_n (rst_n_v[0]), .bus (if_a)
    );
    sr_latch_bank #(.N(4), .EDGE(1'b1), .RST_VAL(4'b1001)) u_dut_b (
        .clk (clk), .rst_n (rst_n_v[1]), .bus (if_b)
    );
    sr_latch_bank #(.N(8), .EDGE(1'b0), .RST_VAL(8'h00)) u_dut_c (
        .clk (clk), .rst_n (rst_n_v[2]), .bus (if_c)
    );
    sr_latch_bank #(.N(1), .EDGE(1'b0), .RST_VAL(1'b0)) u_dut_d (
        .clk (clk), .rst_n (rst_n_v[3]), .bus (if_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus on one instance, queue the expectation,
    // clock once and compare q/chg/cnt/any against the popped entry.
    task automatic step(input int dut, input bit rst, input logic [7:0] set,
                        input logic [7:0] clr, input mode_t mode, input bit excl,
                        input logic [7:0] eq, input logic [7:0] echg, input string tag);
        exp_t       e;
        logic [7:0] oq, ochg, ocnt;
        logic       oany;
        rst_n_v[dut] = ~rst;
        case (dut)
            0: begin if_a.set_i = set[3:0]; if_a.clr_i = clr[3:0]; if_a.mode_i = mode; if_a.excl_i = excl; end
            1: begin if_b.set_i = set[3:0]; if_b.clr_i = clr[3:0]; if_b.mode_i = mode; if_b.excl_i = excl; end
            2: begin if_c.set_i = set;      if_c.clr_i = clr;      if_c.mode_i = mode; if_c.excl_i = excl; end
            default: begin if_d.set_i = set[0:0]; if_d.clr_i = clr[0:0]; if_d.mode_i = mode; if_d.excl_i = excl; end
        endcase
        sb.push_back('{tag: tag, dut: dut, q: eq, chg: echg});
        @(posedge clk);
        #1;
        rst_n_v[dut] = 1'b1;
        e = sb.pop_front();
        case (e.dut)
            0: begin oq = {4'b0, if_a.q_o}; ochg = {4'b0, if_a.chg_o}; ocnt = {5'b0, if_a.cnt_o}; oany = if_a.any_o; end
            1: begin oq = {4'b0, if_b.q_o}; ochg = {4'b0, if_b.chg_o}; ocnt = {5'b0, if_b.cnt_o}; oany = if_b.any_o; end
            2: begin oq = if_c.q_o;         ochg = if_c.chg_o;         ocnt = {4'b0, if_c.cnt_o}; oany = if_c.any_o; end
            default: begin oq = {7'b0, if_d.q_o}; ochg = {7'b0, if_d.chg_o}; ocnt = {7'b0, if_d.cnt_o}; oany = if_d.any_o; end
        endcase
        check({e.tag, ".q"},   oq,   e.q);
        check({e.tag, ".chg"}, ochg, e.chg);
        check({e.tag, ".cnt"}, ocnt, 8'($countones(e.q)));
        check({e.tag, ".any"}, {7'b0, oany}, {7'b0, |e.q});
    endtask

    initial begin
        if_a.set_i = '0; if_a.clr_i = '0; if_a.mode_i = MODE_SET_WINS; if_a.excl_i = 1'b0;
        if_b.set_i = '0; if_b.clr_i = '0; if_b.mode_i = MODE_SET_WINS; if_b.excl_i = 1'b0;
        if_c.set_i = '0; if_c.clr_i = '0; if_c.mode_i = MODE_SET_WINS; if_c.excl_i = 1'b0;
        if_d.set_i = '0; if_d.clr_i = '0; if_d.mode_i = MODE_SET_WINS; if_d.excl_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n_v = 4'b1111;

        // Main instance: reset dominates a full set request.
        step(0, 1, 8'h0F, 8'h00, MODE_SET_WINS, 0, 8'h00, 8'h00, "a_rst");
        step(0, 0, 8'h05, 8'h00, MODE_SET_WINS, 0, 8'h05, 8'h05, "a_set0101");
        // Conflict modes with set=clr=1111.
        step(0, 0, 8'h0F, 8'h0F, MODE_TOGGLE,   0, 8'h0A, 8'h0F, "a_toggle");
        step(0, 0, 8'h05, 8'h0A, MODE_TOGGLE,   0, 8'h05, 8'h0F, "a_restore1");
        step(0, 0, 8'h0F, 8'h0F, MODE_SET_WINS, 0, 8'h0F, 8'h0A, "a_setwins");
        step(0, 0, 8'h00, 8'h0A, MODE_SET_WINS, 0, 8'h05, 8'h0A, "a_restore2");
        step(0, 0, 8'h0F, 8'h0F, MODE_CLR_WINS, 0, 8'h00, 8'h05, "a_clrwins");
        step(0, 0, 8'h05, 8'h00, MODE_CLR_WINS, 0, 8'h05, 8'h05, "a_restore3");
        step(0, 0, 8'h0F, 8'h0F, MODE_HOLD,     0, 8'h05, 8'h00, "a_hold");
        step(0, 0, 8'h00, 8'h00, MODE_HOLD,     0, 8'h05, 8'h00, "a_idle");
        // Exclusive mode: lowest winning set takes the group.
        step(0, 0, 8'h00, 8'h0F, MODE_SET_WINS, 0, 8'h00, 8'h05, "a_clrall");
        step(0, 0, 8'h01, 8'h00, MODE_SET_WINS, 0, 8'h01, 8'h01, "a_set0001");
        step(0, 0, 8'h0C, 8'h00, MODE_SET_WINS, 1, 8'h04, 8'h05, "a_excl_win");
        step(0, 0, 8'h00, 8'h04, MODE_SET_WINS, 1, 8'h00, 8'h04, "a_excl_clr");
        step(0, 0, 8'h0B, 8'h00, MODE_SET_WINS, 0, 8'h0B, 8'h0B, "a_multi");
        step(0, 0, 8'h00, 8'h00, MODE_SET_WINS, 1, 8'h0B, 8'h00, "a_excl_keep");
        step(0, 0, 8'h00, 8'h01, MODE_SET_WINS, 1, 8'h0A, 8'h01, "a_excl_clr0");
        // A set that loses its conflict is not a winner; only the clear acts.
        step(0, 0, 8'h02, 8'h02, MODE_CLR_WINS, 1, 8'h08, 8'h02, "a_excl_lose");
        step(0, 0, 8'h0F, 8'h00, MODE_SET_WINS, 1, 8'h01, 8'h09, "a_excl_low");
        // Reset in the middle of operation, then resume in level mode.
        step(0, 0, 8'h0F, 8'h00, MODE_SET_WINS, 0, 8'h0F, 8'h0E, "a_fill");
        step(0, 1, 8'h02, 8'h00, MODE_SET_WINS, 0, 8'h00, 8'h00, "a_midrst");
        step(0, 0, 8'h02, 8'h00, MODE_SET_WINS, 0, 8'h02, 8'h02, "a_after_rst");
        step(0, 0, 8'h0F, 8'h00, MODE_SET_WINS, 0, 8'h0F, 8'h0D, "a_count4");

        // Edge instance, RST_VAL=1001; request high through reset still counts.
        step(1, 1, 8'h04, 8'h00, MODE_SET_WINS, 0, 8'h09, 8'h00, "b_rst");
        step(1, 0, 8'h04, 8'h00, MODE_SET_WINS, 0, 8'h0D, 8'h04, "b_first_edge");
        step(1, 0, 8'h04, 8'h00, MODE_SET_WINS, 0, 8'h0D, 8'h00, "b_held");
        step(1, 0, 8'h06, 8'h00, MODE_SET_WINS, 0, 8'h0F, 8'h02, "b_set1_rise");
        step(1, 0, 8'h06, 8'h00, MODE_SET_WINS, 0, 8'h0F, 8'h00, "b_set1_hold1");
        step(1, 0, 8'h06, 8'h00, MODE_SET_WINS, 0, 8'h0F, 8'h00, "b_set1_hold2");
        step(1, 0, 8'h00, 8'h02, MODE_SET_WINS, 0, 8'h0D, 8'h02, "b_clr1_rise");
        step(1, 0, 8'h00, 8'h02, MODE_SET_WINS, 0, 8'h0D, 8'h00, "b_clr1_hold1");
        step(1, 0, 8'h00, 8'h02, MODE_SET_WINS, 0, 8'h0D, 8'h00, "b_clr1_hold2");

        // N=8: full count of 8 in a 4-bit counter, exclusive on the top bit.
        step(2, 1, 8'hFF, 8'h00, MODE_SET_WINS, 0, 8'h00, 8'h00, "c_rst");
        step(2, 0, 8'hFF, 8'h00, MODE_SET_WINS, 0, 8'hFF, 8'hFF, "c_full");
        step(2, 0, 8'h80, 8'h00, MODE_SET_WINS, 1, 8'h80, 8'h7F, "c_excl_top");
        step(2, 0, 8'h00, 8'h80, MODE_SET_WINS, 0, 8'h00, 8'h80, "c_clr_top");

        // N=1 corner.
        step(3, 1, 8'h01, 8'h00, MODE_SET_WINS, 0, 8'h00, 8'h00, "d_rst");
        step(3, 0, 8'h01, 8'h00, MODE_SET_WINS, 0, 8'h01, 8'h01, "d_set");
        step(3, 0, 8'h01, 8'h01, MODE_TOGGLE,   0, 8'h00, 8'h01, "d_toggle");
        step(3, 0, 8'h01, 8'h00, MODE_SET_WINS, 1, 8'h01, 8'h01, "d_excl");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sr_latch_bank
`default_nettype wire
